// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV64 pipeline: load-use detection,
// stall/flush arbitration between execute and memory, and precise trap entry sequencing.
module pipeline_ctrl #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            id_valid,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_rs1_used,
    input  logic            id_rs2_used,
    input  logic [4:0]      id_rd,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_trap,
    input  logic [3:0]      id_trap_cause,
    input  logic [XLEN-1:0] id_pc,
    input  logic            ex_redirect,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_busy,
    input  logic            mem_busy,
    input  logic [XLEN-1:0] mtvec,
    output logic            stall_if,
    output logic            stall_id,
    output logic            stall_ex,
    output logic            flush_id,
    output logic            flush_ex,
    output logic            pc_redirect,
    output logic [XLEN-1:0] pc_target,
    output logic            trap_taken,
    output logic [3:0]      trap_cause,
    output logic [XLEN-1:0] trap_epc,
    output logic            load_use,
    output logic [1:0]      state
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        REDIRECT = 2'd2,
        UNUSED   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        drain_cnt_q, drain_cnt_d;
    logic              ex_v_q, ex_v_d;
    logic [4:0]        ex_rd_q, ex_rd_d;
    logic              ex_ld_q, ex_ld_d;
    logic [3:0]        trap_cause_q, trap_cause_d;
    logic [XLEN-1:0]   trap_epc_q, trap_epc_d;
    logic              rs1_hit, rs2_hit;

    assign rs1_hit    = id_rs1_used && (id_rs1 == ex_rd_q);
    assign rs2_hit    = id_rs2_used && (id_rs2 == ex_rd_q);
    assign load_use   = id_valid && ex_v_q && ex_ld_q && (ex_rd_q != 5'd0) && (rs1_hit || rs2_hit);
    assign state      = state_q;
    assign trap_cause = trap_cause_q;
    assign trap_epc   = trap_epc_q;

    always_comb begin
        stall_if     = 1'b0;
        stall_id     = 1'b0;
        stall_ex     = 1'b0;
        flush_id     = 1'b0;
        flush_ex     = 1'b0;
        pc_redirect  = 1'b0;
        pc_target    = '0;
        trap_taken   = 1'b0;
        state_d      = state_q;
        drain_cnt_d  = drain_cnt_q;
        trap_cause_d = trap_cause_q;
        trap_epc_d   = trap_epc_q;

        case (state_q)
            RUN: begin
                if (mem_busy || ex_busy) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    stall_ex = 1'b1;
                end else if (ex_redirect) begin
                    // Decode holds a wrong-path instruction, so its hazards and traps are moot.
                    pc_redirect = 1'b1;
                    pc_target   = ex_target;
                    flush_id    = 1'b1;
                end else if (load_use) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    flush_ex = 1'b1;
                end else if (id_valid && id_trap) begin
                    flush_id     = 1'b1;
                    stall_if     = 1'b1;
                    trap_cause_d = id_trap_cause;
                    trap_epc_d   = id_pc;
                    drain_cnt_d  = 2'd0;
                    state_d      = DRAIN;
                end
            end
            DRAIN: begin
                stall_if = 1'b1;
                flush_id = 1'b1;
                flush_ex = 1'b1;
                // Two memory-idle cycles retire everything older than the trap; leave
                // on the cycle the count reaches two.
                if (!mem_busy) begin
                    drain_cnt_d = (drain_cnt_q == 2'd2) ? 2'd2 : drain_cnt_q + 2'd1;
                    if (drain_cnt_d == 2'd2) begin
                        state_d = REDIRECT;
                    end
                end
            end
            REDIRECT: begin
                pc_redirect = 1'b1;
                pc_target   = {mtvec[XLEN-1:2], 2'b00};
                trap_taken  = 1'b1;
                flush_id    = 1'b1;
                flush_ex    = 1'b1;
                state_d     = RUN;
            end
            default: state_d = RUN;
        endcase

        ex_v_d  = ex_v_q;
        ex_rd_d = ex_rd_q;
        ex_ld_d = ex_ld_q;
        if (!stall_ex) begin
            if (flush_ex || flush_id) begin
                ex_v_d  = 1'b0;
                ex_rd_d = 5'd0;
                ex_ld_d = 1'b0;
            end else begin
                ex_v_d  = id_valid && id_reg_write;
                ex_rd_d = id_rd;
                ex_ld_d = id_mem_read;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= RUN;
            drain_cnt_q  <= 2'd0;
            ex_v_q       <= 1'b0;
            ex_rd_q      <= 5'd0;
            ex_ld_q      <= 1'b0;
            trap_cause_q <= 4'd0;
            trap_epc_q   <= '0;
        end else begin
            state_q      <= state_d;
            drain_cnt_q  <= drain_cnt_d;
            ex_v_q       <= ex_v_d;
            ex_rd_q      <= ex_rd_d;
            ex_ld_q      <= ex_ld_d;
            trap_cause_q <= trap_cause_d;
            trap_epc_q   <= trap_epc_d;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed vector table, hand-written trap/reset sequences,
// and randomized traffic checked against a behavioural model of the pipeline rules.
module tb_pipeline_ctrl;
    localparam int XLEN = 64;

    typedef struct packed {
        logic        stall_if;
        logic        stall_id;
        logic        stall_ex;
        logic        flush_id;
        logic        flush_ex;
        logic        pc_redirect;
        logic [63:0] pc_target;
        logic        trap_taken;
        logic [3:0]  trap_cause;
        logic [63:0] trap_epc;
        logic        load_use;
        logic [1:0]  state;
    } out_t;
    localparam int OW = $bits(out_t);

    typedef struct {
        logic        v;
        logic [4:0]  rs1;
        logic        rs1u;
        logic [4:0]  rd;
        logic        rw;
        logic        ld;
        logic        trap;
        logic [3:0]  cause;
        logic [63:0] pc;
        logic        redir;
        logic [63:0] tgt;
        logic        exb;
        logic        memb;
        logic [5:0]  fl;
        logic        tt;
        logic        lu;
        logic [1:0]  st;
        logic [63:0] etgt;
        logic [3:0]  ecause;
        logic [63:0] eepc;
    } vec_t;

    logic clk = 1'b0;
    logic resetn;
    logic id_valid, id_rs1_used, id_rs2_used, id_reg_write, id_mem_read, id_trap;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic [3:0] id_trap_cause;
    logic [XLEN-1:0] id_pc, ex_target, mtvec;
    logic ex_redirect, ex_busy, mem_busy;
    logic stall_if, stall_id, stall_ex, flush_id, flush_ex, pc_redirect, trap_taken, load_use;
    logic [XLEN-1:0] pc_target, trap_epc;
    logic [3:0] trap_cause;
    logic [1:0] state;

    out_t act;
    logic [OW-1:0] exp_q[$];
    vec_t vecs[$];
    int n_checks = 0;
    int n_pass = 0;

    // Reference model state: which phase of trap handling we are in and how many
    // memory-idle drain cycles have elapsed, plus the last instruction sent to execute.
    int m_mode;
    int m_clean;
    logic m_v, m_ld;
    logic [4:0] m_rd;
    logic [3:0] m_cause;
    logic [63:0] m_epc;

    always #5 clk = ~clk;

    pipeline_ctrl #(.XLEN(XLEN)) dut (
        .clk(clk), .resetn(resetn),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_trap(id_trap), .id_trap_cause(id_trap_cause), .id_pc(id_pc),
        .ex_redirect(ex_redirect), .ex_target(ex_target),
        .ex_busy(ex_busy), .mem_busy(mem_busy), .mtvec(mtvec),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
        .flush_id(flush_id), .flush_ex(flush_ex),
        .pc_redirect(pc_redirect), .pc_target(pc_target),
        .trap_taken(trap_taken), .trap_cause(trap_cause), .trap_epc(trap_epc),
        .load_use(load_use), .state(state)
    );

    assign act = {stall_if, stall_id, stall_ex, flush_id, flush_ex, pc_redirect, pc_target,
                  trap_taken, trap_cause, trap_epc, load_use, state};

    task automatic model_reset();
        m_mode = 0; m_clean = 0; m_v = 1'b0; m_ld = 1'b0; m_rd = 5'd0;
        m_cause = 4'd0; m_epc = 64'd0;
    endtask

    function automatic logic model_lu();
        return id_valid && m_v && m_ld && (m_rd != 5'd0) &&
               ((id_rs1_used && id_rs1 == m_rd) || (id_rs2_used && id_rs2 == m_rd));
    endfunction

    function automatic out_t model_out();
        out_t o;
        o = '0;
        o.load_use   = model_lu();
        o.trap_cause = m_cause;
        o.trap_epc   = m_epc;
        o.state      = 2'(m_mode);
        if (m_mode == 0) begin
            if (mem_busy || ex_busy) begin
                o.stall_if = 1'b1; o.stall_id = 1'b1; o.stall_ex = 1'b1;
            end else if (ex_redirect) begin
                o.pc_redirect = 1'b1; o.pc_target = ex_target; o.flush_id = 1'b1;
            end else if (o.load_use) begin
                o.stall_if = 1'b1; o.stall_id = 1'b1; o.flush_ex = 1'b1;
            end else if (id_valid && id_trap) begin
                o.flush_id = 1'b1; o.stall_if = 1'b1;
            end
        end else if (m_mode == 1) begin
            o.stall_if = 1'b1; o.flush_id = 1'b1; o.flush_ex = 1'b1;
        end else begin
            o.pc_redirect = 1'b1; o.pc_target = mtvec & ~64'h3;
            o.trap_taken = 1'b1; o.flush_id = 1'b1; o.flush_ex = 1'b1;
        end
        return o;
    endfunction

    task automatic model_step();
        out_t o;
        logic enter;
        if (!resetn) begin
            model_reset();
            return;
        end
        o = model_out();
        enter = (m_mode == 0) && !mem_busy && !ex_busy && !ex_redirect && !o.load_use &&
                id_valid && id_trap;
        if (!o.stall_ex) begin
            if (o.flush_ex || o.flush_id) m_v = 1'b0;
            else begin
                m_v = id_valid && id_reg_write; m_rd = id_rd; m_ld = id_mem_read;
            end
        end
        if (m_mode == 0) begin
            if (enter) begin
                m_mode = 1; m_clean = 0; m_cause = id_trap_cause; m_epc = id_pc;
            end
        end else if (m_mode == 1) begin
            if (!mem_busy) m_clean++;
            if (m_clean >= 2) m_mode = 2;
        end else begin
            m_mode = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic drive_idle();
        id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        id_rd = 5'd0; id_reg_write = 1'b0; id_mem_read = 1'b0; id_trap = 1'b0;
        id_trap_cause = 4'd0; id_pc = 64'd0; ex_redirect = 1'b0; ex_target = 64'd0;
        ex_busy = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic compare_bundle(input string name, input logic [OW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_val(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, want);
    endtask

    task automatic check(input string name);
        out_t e;
        e = model_out();
        exp_q.push_back(e);
        compare_bundle(name, exp_q.pop_front());
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        drive_idle();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic add_vec(input int v, input int rs1, input int rs1u, input int rd,
                           input int rw, input int ld, input int trap, input int cause,
                           input logic [63:0] pc, input int redir, input logic [63:0] tgt,
                           input int exb, input int memb, input int fl, input int tt,
                           input int lu, input int st, input logic [63:0] etgt,
                           input int ecause, input logic [63:0] eepc);
        vec_t r;
        r.v = 1'(v); r.rs1 = 5'(rs1); r.rs1u = 1'(rs1u); r.rd = 5'(rd); r.rw = 1'(rw);
        r.ld = 1'(ld); r.trap = 1'(trap); r.cause = 4'(cause); r.pc = pc;
        r.redir = 1'(redir); r.tgt = tgt; r.exb = 1'(exb); r.memb = 1'(memb);
        r.fl = 6'(fl); r.tt = 1'(tt); r.lu = 1'(lu); r.st = 2'(st); r.etgt = etgt;
        r.ecause = 4'(ecause); r.eepc = eepc;
        vecs.push_back(r);
    endtask

    initial begin
        int k;
        int tt_seen;
        out_t e;
        vec_t r;

        // Flags order: {stall_if, stall_id, stall_ex, flush_id, flush_ex, pc_redirect}
        add_vec(1, 0, 0, 1, 1, 1, 0, 0, 64'h0, 0, 64'h0, 0, 0, 'b000000, 0, 0, 0, 64'h0, 0, 64'h0);
        add_vec(1, 1, 1, 2, 1, 0, 0, 0, 64'h0, 0, 64'h0, 0, 0, 'b110010, 0, 1, 0, 64'h0, 0, 64'h0);
        add_vec(1, 1, 1, 2, 1, 0, 0, 0, 64'h0, 0, 64'h0, 0, 0, 'b000000, 0, 0, 0, 64'h0, 0, 64'h0);
        add_vec(0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 0, 64'h0, 0, 0, 'b000000, 0, 0, 0, 64'h0, 0, 64'h0);
        add_vec(1, 0, 0, 0, 1, 1, 0, 0, 64'h0, 0, 64'h0, 0, 0, 'b000000, 0, 0, 0, 64'h0, 0, 64'h0);
        add_vec(1, 0, 1, 5, 1, 0, 0, 0, 64'h0, 0, 64'h0, 0, 0, 'b000000, 0, 0, 0, 64'h0, 0, 64'h0);
        add_vec(1, 0, 0, 3, 1, 1, 0, 0, 64'h0, 0, 64'h0, 0, 0, 'b000000, 0, 0, 0, 64'h0, 0, 64'h0);
        add_vec(1, 3, 0, 6, 1, 0, 0, 0, 64'h0, 0, 64'h0, 0, 0, 'b000000, 0, 0, 0, 64'h0, 0, 64'h0);
        add_vec(1, 0, 0, 4, 1, 1, 0, 0, 64'h0, 0, 64'h0, 0, 0, 'b000000, 0, 0, 0, 64'h0, 0, 64'h0);
        add_vec(1, 4, 1, 7, 1, 0, 0, 0, 64'h0, 1, 64'h2000, 0, 0, 'b000101, 0, 1, 0, 64'h2000, 0, 64'h0);
        add_vec(0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 0, 64'h0, 0, 0, 'b000000, 0, 0, 0, 64'h0, 0, 64'h0);
        add_vec(1, 0, 0, 0, 0, 0, 1, 2, 64'h1040, 0, 64'h0, 0, 0, 'b100100, 0, 0, 0, 64'h0, 0, 64'h0);
        add_vec(0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 0, 64'h0, 0, 0, 'b100110, 0, 0, 1, 64'h0, 2, 64'h1040);
        add_vec(0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 0, 64'h0, 0, 0, 'b100110, 0, 0, 1, 64'h0, 2, 64'h1040);
        add_vec(0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 0, 64'h0, 0, 0, 'b000111, 1, 0, 2, 64'h8000, 2, 64'h1040);
        add_vec(0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 0, 64'h0, 0, 0, 'b000000, 0, 0, 0, 64'h0, 2, 64'h1040);
        add_vec(1, 0, 0, 0, 0, 0, 0, 0, 64'h0, 0, 64'h0, 1, 0, 'b111000, 0, 0, 0, 64'h0, 2, 64'h1040);
        add_vec(0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 1, 64'h3000, 0, 1, 'b111000, 0, 0, 0, 64'h0, 2, 64'h1040);
        add_vec(0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 1, 64'h3004, 0, 0, 'b000101, 0, 0, 0, 64'h3004, 2, 64'h1040);

        mtvec = 64'h8001;
        do_reset();
        #1 compare_bundle("reset_state", '0);

        foreach (vecs[i]) begin
            r = vecs[i];
            id_valid = r.v; id_rs1 = r.rs1; id_rs1_used = r.rs1u; id_rs2 = 5'd0; id_rs2_used = 1'b0;
            id_rd = r.rd; id_reg_write = r.rw; id_mem_read = r.ld; id_trap = r.trap;
            id_trap_cause = r.cause; id_pc = r.pc; ex_redirect = r.redir; ex_target = r.tgt;
            ex_busy = r.exb; mem_busy = r.memb;
            e = '0;
            {e.stall_if, e.stall_id, e.stall_ex, e.flush_id, e.flush_ex, e.pc_redirect} = r.fl;
            e.pc_target = r.etgt; e.trap_taken = r.tt; e.trap_cause = r.ecause;
            e.trap_epc = r.eepc; e.load_use = r.lu; e.state = r.st;
            #1 compare_bundle($sformatf("vec%0d", i), e);
            tick();
        end

        // Trap entry with memory busy through the first three drain cycles.
        do_reset();
        id_valid = 1'b1; id_trap = 1'b1; id_trap_cause = 4'd11; id_pc = 64'h2200;
        #1 check("t5_entry");
        tick();
        drive_idle();
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("t5_drain_busy");
            check_val("t5_stall_if_busy", int'(stall_if), 1);
            tick();
        end
        mem_busy = 1'b0;
        k = -1;
        for (int i = 0; i < 8; i++) begin
            #1 check("t5_drain_free");
            if (state == 2'd2) k = i;
            else check_val("t5_stall_if_free", int'(stall_if), 1);
            tick();
            if (k >= 0) break;
        end
        check_val("t5_redirect_delay", k, 2);
        #1 check("t5_latched");

        // Asynchronous reset in the middle of a drain.
        tick();
        do_reset();
        id_valid = 1'b1; id_trap = 1'b1; id_trap_cause = 4'd3; id_pc = 64'h4444;
        #1 check("t6_entry");
        tick();
        drive_idle();
        #1 check("t6_drain");
        #2 resetn = 1'b0;
        #1 compare_bundle("t6_async_reset", '0);
        model_reset();
        tick();
        resetn = 1'b1;
        tt_seen = 0;
        for (int i = 0; i < 6; i++) begin
            #1 check("t6_after_reset");
            if (trap_taken) tt_seen++;
            tick();
        end
        check_val("t6_no_trap_taken", tt_seen, 0);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            id_valid      = ($urandom_range(0, 3) != 0);
            id_rs1        = 5'($urandom_range(0, 3));
            id_rs2        = 5'($urandom_range(0, 3));
            id_rs1_used   = 1'($urandom_range(0, 1));
            id_rs2_used   = 1'($urandom_range(0, 1));
            id_rd         = 5'($urandom_range(0, 3));
            id_reg_write  = 1'($urandom_range(0, 1));
            id_mem_read   = ($urandom_range(0, 2) == 0);
            id_trap       = ($urandom_range(0, 15) == 0);
            id_trap_cause = 4'($urandom());
            id_pc         = {$urandom(), $urandom()};
            ex_redirect   = ($urandom_range(0, 7) == 0);
            ex_target     = {$urandom(), $urandom()};
            ex_busy       = ($urandom_range(0, 7) == 0);
            mem_busy      = ($urandom_range(0, 5) == 0);
            mtvec         = {$urandom(), $urandom()};
            #1 check($sformatf("rand%0d", i));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
